btn_event_decoder: RTL and testbench
====================================

Name: btn_event_decoder

Overview:
- Consumes the debounced, clean button level and turns it into single-cycle gesture events for control logic: press/release edges, short click, double click, long press.
- Sits directly downstream of the button debouncer, one instance per button.
- Input must already be glitch-free. No filtering is done here.

Parameters:
- LONG_TICKS, 10_000_000, cycles the button must stay held after press detection to count as a long press (1 s at 10 MHz); must be ≥2.
- DCLICK_TICKS, 3_000_000, maximum cycles between the first release and the second press for a double click (0.3 s at 10 MHz); must be ≥2.
- CNT_W, 24, timer width; must hold max(LONG_TICKS, DCLICK_TICKS)-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- btn_in  input  1  debounced button level, 1 = pressed, synchronous to clk
- held  output  1  registered copy of btn_in
- press_pulse  output  1  one-cycle pulse on each detected press
- release_pulse  output  1  one-cycle pulse on each detected release
- short_click  output  1  one-cycle pulse: single press/release, no second press within window
- double_click  output  1  one-cycle pulse: second release of a double click
- long_press  output  1  one-cycle pulse when the hold reaches LONG_TICKS

Behaviour:
- Reset (async assert, sync release):
  - All outputs = 0; state = IDLE; timer = 0.
  - Internal previous-level register btn_q resets to 1, so a button held through reset is ignored until btn_in is seen 0.
- Edge detection: rise = btn_in & ~btn_q; fall = ~btn_in & btn_q; btn_q <= btn_in every cycle.
- All event outputs are registered. Each is high for exactly one cycle, in the cycle after the edge at which the condition was sampled.
- press_pulse and release_pulse fire on every rise and every fall, in every state. They are independent of the FSM.
- FSM states: IDLE, PRESS1, LONG, WAIT2, PRESS2. Timer is cleared on entry to PRESS1 and WAIT2, and increments by 1 each cycle in those states.
  - IDLE: rise → PRESS1.
  - PRESS1:
    - fall → WAIT2.
    - Else if timer == LONG_TICKS-1 → LONG, with long_press. long_press therefore rises exactly LONG_TICKS cycles after press_pulse rose.
    - Fall on the same edge as timer == LONG_TICKS-1: fall wins (→ WAIT2, no long_press).
  - LONG: fall → IDLE. No click event is ever produced from a long press.
  - WAIT2:
    - rise → PRESS2.
    - Else if timer == DCLICK_TICKS-1 → IDLE, with short_click.
    - Rise on the same edge as timeout: rise wins (→ PRESS2, no short_click).
  - PRESS2: fall → IDLE, with double_click. Hold duration in PRESS2 is unbounded and does not produce long_press.
- Third and further presses: a rise in IDLE after double_click starts a new gesture.
- Timer saturates at its terminal value and never wraps. Transitions leave the state before wrap is possible.
- Reset mid-gesture aborts it: no pending event is emitted after rst_n deasserts.
- Pulse timing with the rules above:
  - press_pulse and release_pulse follow btn_in edges by 1 cycle.
  - short_click is high in the cycle after WAIT2 times out.
  - double_click coincides with the second release_pulse.

Test Plan:
- LONG_TICKS=8, DCLICK_TICKS=5, reset then btn_in=1 for 3 cycles, then 0 for 10 cycles:
  - press_pulse one cycle after the rise; release_pulse one cycle after the fall.
  - short_click exactly 5 cycles after release_pulse.
  - No long_press or double_click.
- Same parameters, btn_in=1 for 12 cycles:
  - long_press exactly 8 cycles after press_pulse.
  - On release, release_pulse only; no short_click.
- btn_in 1 (2 cycles), 0 (2 cycles), 1 (4 cycles), 0:
  - press_pulse ×2, release_pulse ×2.
  - double_click in the same cycle as the second release_pulse; no short_click.
- Boundary cases:
  - Release on the cycle timer==7 in PRESS1 → short path: short_click, no long_press.
  - Second press on the cycle timer==4 in WAIT2 → double_click path.
- Hold btn_in=1 through reset and release:
  - No press_pulse until btn_in goes 0 then 1.
  - Assert rst_n=0 mid-PRESS1 → all outputs 0 immediately, no later event.

Source files
------------

// File: rtl/btn_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : btn_event_decoder
// Purpose  : Turns a debounced button level into single-cycle gesture events:
//            press/release edges, short click, double click and long press.
// Revision : 1.0 - initial release
// ============================================================================
module btn_event_decoder #(
  parameter int LONG_TICKS   = 10_000_000,
  parameter int DCLICK_TICKS = 3_000_000,
  parameter int CNT_W        = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRESS1 = 3'd1;
  localparam logic [2:0] S_LONG   = 3'd2;
  localparam logic [2:0] S_WAIT2  = 3'd3;
  localparam logic [2:0] S_PRESS2 = 3'd4;

  localparam logic [CNT_W-1:0] C_LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] C_DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);
  localparam logic [CNT_W-1:0] C_TIMER_MAX   = {CNT_W{1'b1}};

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_nxt;
  logic             r_btn_q;
  logic             w_rise;
  logic             w_fall;
  logic             w_short;
  logic             w_double;
  logic             w_long;

  // r_btn_q resets high so a button held through reset produces no press
  assign w_rise = btn_in & ~r_btn_q;
  assign w_fall = ~btn_in & r_btn_q;

  // State and gesture timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next-state and timer update: timer restarts on every state change and
  // counts (saturating) only while a timed state is held
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_rise) w_state_nxt = S_PRESS1;
      S_PRESS1: begin
        if (w_fall)                       w_state_nxt = S_WAIT2;
        else if (r_timer == C_LONG_LAST)  w_state_nxt = S_LONG;
      end
      S_LONG:   if (w_fall) w_state_nxt = S_IDLE;
      S_WAIT2:  begin
        if (w_rise)                        w_state_nxt = S_PRESS2;
        else if (r_timer == C_DCLICK_LAST) w_state_nxt = S_IDLE;
      end
      S_PRESS2: if (w_fall) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    w_timer_nxt = r_timer;
    if (w_state_nxt != r_state) begin
      w_timer_nxt = '0;
    end else if ((r_state == S_PRESS1 || r_state == S_WAIT2) &&
                 (r_timer != C_TIMER_MAX)) begin
      w_timer_nxt = r_timer + 1'b1;
    end
  end

  // Gesture event decode; edge priority over timeouts is inherited from
  // the next-state ordering above
  always_comb begin
    w_short  = 1'b0;
    w_double = 1'b0;
    w_long   = 1'b0;
    case (r_state)
      S_PRESS1: w_long   = ~w_fall && (r_timer == C_LONG_LAST);
      S_WAIT2:  w_short  = ~w_rise && (r_timer == C_DCLICK_LAST);
      S_PRESS2: w_double = w_fall;
      default:  ;
    endcase
  end

  // Registered level copy, edge pulses and gesture event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_q       <= 1'b1;
      held          <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_click   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      r_btn_q       <= btn_in;
      held          <= btn_in;
      press_pulse   <= w_rise;
      release_pulse <= w_fall;
      short_click   <= w_short;
      double_click  <= w_double;
      long_press    <= w_long;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_event_decoder
// Purpose  : Self-checking bench for btn_event_decoder with a gesture model
//            feeding an expected-output queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_event_decoder;

  localparam int LONG_TICKS   = 8;
  localparam int DCLICK_TICKS = 5;
  localparam int CNT_W        = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_DOWN1 = 1;
  localparam int PH_LONG  = 2;
  localparam int PH_GAP   = 3;
  localparam int PH_DOWN2 = 4;

  logic clk;
  logic rst_n;
  logic btn_in;
  logic held, press_pulse, release_pulse, short_click, double_click, long_press;

  btn_event_decoder #(
    .LONG_TICKS   (LONG_TICKS),
    .DCLICK_TICKS (DCLICK_TICKS),
    .CNT_W        (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .held          (held),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_click   (short_click),
    .double_click  (double_click),
    .long_press    (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] exp_q[$];

  // gesture model state
  logic m_prev;
  int   m_phase;
  int   m_elapsed;

  // per-scenario observations
  int cyc;
  int n_press, n_rel, n_short, n_dbl, n_long;
  int t_press, t_rel, t_short, t_dbl, t_long;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {held, press_pulse, release_pulse, short_click, double_click, long_press};
  endfunction

  task automatic model_reset();
    m_prev    = 1'b1;
    m_phase   = PH_IDLE;
    m_elapsed = 0;
    exp_q.delete();
  endtask

  // Expected outputs visible after the clock edge that samples b
  task automatic model_step(input logic b, output logic [5:0] e);
    logic rise, fall, sc, dc, lp;
    rise = b & ~m_prev;
    fall = ~b & m_prev;
    sc = 1'b0; dc = 1'b0; lp = 1'b0;
    case (m_phase)
      PH_IDLE: if (rise) begin m_phase = PH_DOWN1; m_elapsed = 0; end
      PH_DOWN1: begin
        m_elapsed++;
        if (fall) begin
          m_phase = PH_GAP; m_elapsed = 0;
        end else if (m_elapsed == LONG_TICKS) begin
          lp = 1'b1; m_phase = PH_LONG;
        end
      end
      PH_LONG: if (fall) m_phase = PH_IDLE;
      PH_GAP: begin
        m_elapsed++;
        if (rise) begin
          m_phase = PH_DOWN2;
        end else if (m_elapsed == DCLICK_TICKS) begin
          sc = 1'b1; m_phase = PH_IDLE;
        end
      end
      PH_DOWN2: if (fall) begin dc = 1'b1; m_phase = PH_IDLE; end
      default: m_phase = PH_IDLE;
    endcase
    e = {b, rise, fall, sc, dc, lp};
    m_prev = b;
  endtask

  task automatic clear_stats();
    n_press = 0; n_rel = 0; n_short = 0; n_dbl = 0; n_long = 0;
    t_press = -1; t_rel = -1; t_short = -1; t_dbl = -1; t_long = -1;
  endtask

  // Called at a falling edge: drive, predict, then compare after the rising edge
  task automatic step(input string tag, input logic b);
    logic [5:0] e;
    logic [5:0] got;
    btn_in = b;
    model_step(b, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = outs();
    cyc++;
    if (got[4]) begin n_press++; t_press = cyc; end
    if (got[3]) begin n_rel++;   t_rel   = cyc; end
    if (got[2]) begin n_short++; t_short = cyc; end
    if (got[1]) begin n_dbl++;   t_dbl   = cyc; end
    if (got[0]) begin n_long++;  t_long  = cyc; end
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      check_eq(tag, {26'd0, got}, {26'd0, exp_q.pop_front()});
    end
    @(negedge clk);
  endtask

  task automatic drive(input string tag, input logic b, input int n);
    for (int i = 0; i < n; i++) step(tag, b);
  endtask

  initial begin
    rst_n  = 1'b0;
    btn_in = 1'b0;
    cyc    = 0;
    clear_stats();
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset_outs", {26'd0, outs()}, 32'd0);
    rst_n = 1'b1;

    // idle after reset (btn_q starts high, so a release edge is expected)
    drive("idle", 1'b0, 2);

    // single short click
    clear_stats();
    drive("click", 1'b1, 3);
    drive("click", 1'b0, 10);
    check_eq("click_press_n", n_press, 1);
    check_eq("click_short_n", n_short, 1);
    check_eq("click_short_lat", t_short - t_rel, DCLICK_TICKS);
    check_eq("click_other_n", n_long + n_dbl, 0);

    // long press
    clear_stats();
    drive("long", 1'b1, 12);
    drive("long", 1'b0, 8);
    check_eq("long_n", n_long, 1);
    check_eq("long_lat", t_long - t_press, LONG_TICKS);
    check_eq("long_rel_n", n_rel, 1);
    check_eq("long_short_n", n_short + n_dbl, 0);

    // double click
    clear_stats();
    drive("dbl", 1'b1, 2);
    drive("dbl", 1'b0, 2);
    drive("dbl", 1'b1, 4);
    drive("dbl", 1'b0, 8);
    check_eq("dbl_press_n", n_press, 2);
    check_eq("dbl_rel_n", n_rel, 2);
    check_eq("dbl_n", n_dbl, 1);
    check_eq("dbl_with_rel", t_dbl, t_rel);
    check_eq("dbl_short_n", n_short, 0);

    // release on the last cycle before long press fires
    clear_stats();
    drive("edge_long", 1'b1, LONG_TICKS);
    drive("edge_long", 1'b0, 8);
    check_eq("edge_long_n", n_long, 0);
    check_eq("edge_long_short_n", n_short, 1);

    // second press on the last cycle of the double-click window
    clear_stats();
    drive("edge_dbl", 1'b1, 2);
    drive("edge_dbl", 1'b0, DCLICK_TICKS);
    drive("edge_dbl", 1'b1, 3);
    drive("edge_dbl", 1'b0, 8);
    check_eq("edge_dbl_n", n_dbl, 1);
    check_eq("edge_dbl_short_n", n_short, 0);

    // second press one cycle too late: two separate short clicks
    clear_stats();
    drive("late_dbl", 1'b1, 2);
    drive("late_dbl", 1'b0, DCLICK_TICKS + 1);
    drive("late_dbl", 1'b1, 2);
    drive("late_dbl", 1'b0, 8);
    check_eq("late_dbl_short_n", n_short, 2);
    check_eq("late_dbl_n", n_dbl, 0);

    // button held through reset is ignored until it is seen released
    rst_n  = 1'b0;
    btn_in = 1'b1;
    #1;
    check_eq("held_rst_outs", {26'd0, outs()}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    clear_stats();
    drive("held_rst", 1'b1, 5);
    check_eq("held_rst_press_n", n_press, 0);
    drive("held_rst", 1'b0, 2);
    drive("held_rst", 1'b1, 3);
    drive("held_rst", 1'b0, 8);
    check_eq("held_rst_press2_n", n_press, 1);

    // reset in the middle of a press aborts the gesture
    drive("abort", 1'b0, 2);
    drive("abort", 1'b1, 3);
    rst_n = 1'b0;
    #1;
    check_eq("abort_outs", {26'd0, outs()}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    clear_stats();
    drive("abort", 1'b1, LONG_TICKS + 4);
    drive("abort", 1'b0, 8);
    check_eq("abort_events_n", n_press + n_long + n_short + n_dbl, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
